// File: rtl/er_cde_generator.sv
// Stack/memory fault detector: validates LOAD/STORE/PUSH/POP/CALL/RET requests against the
// stack window and tracked depth, latches the first fault as an error code and halts the core.
module er_cde_generator #(
  parameter int unsigned         ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]   STACK_BASE  = 8'hF0,
  parameter int unsigned         STACK_DEPTH = 16,
  parameter int unsigned         DEPTH_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic               err_clr,
  output logic               op_grant,
  output logic [7:0]         ER_CDE,
  output logic               halt,
  output logic [DEPTH_W-1:0] sp_depth,
  output logic [ADDR_W-1:0]  fault_addr,
  output logic [3:0]         fault_cnt
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  localparam logic [2:0] OpLoad  = 3'd1;
  localparam logic [2:0] OpStore = 3'd2;
  localparam logic [2:0] OpPush  = 3'd3;
  localparam logic [2:0] OpPop   = 3'd4;
  localparam logic [2:0] OpCall  = 3'd5;
  localparam logic [2:0] OpRet   = 3'd6;

  // Window bounds held one bit wider so STACK_BASE+STACK_DEPTH-1 cannot wrap.
  localparam logic [ADDR_W:0]    StackLo   = {1'b0, STACK_BASE};
  localparam logic [ADDR_W:0]    StackHi   = StackLo + (ADDR_W+1)'(STACK_DEPTH - 1);
  localparam logic [DEPTH_W-1:0] DepthFull = DEPTH_W'(STACK_DEPTH);

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic [7:0]         code_q, code_d;
  logic               halt_q, halt_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [ADDR_W-1:0]  faddr_q, faddr_d;
  logic [3:0]         fcnt_q, fcnt_d;

  logic       in_stack, full, empty;
  logic [7:0] err_code;

  assign in_stack = ({1'b0, mem_addr} >= StackLo) && ({1'b0, mem_addr} <= StackHi);
  assign full     = (depth_q == DepthFull);
  assign empty    = (depth_q == '0);

  always_comb begin
    err_code = 8'h00;
    case (op_code)
      OpLoad:  if (in_stack) err_code = 8'h01;
      OpStore: if (in_stack) err_code = 8'h02;
      OpPush:  if (full)     err_code = 8'h03;
      OpPop:   if (empty)    err_code = 8'h04;
      OpRet:   if (empty)    err_code = 8'h05;
      OpCall:  if (full)     err_code = 8'h06;
      default: err_code = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      grant_q <= 1'b0;
      code_q  <= 8'h00;
      halt_q  <= 1'b0;
      depth_q <= '0;
      faddr_q <= '0;
      fcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      code_q  <= code_d;
      halt_q  <= halt_d;
      depth_q <= depth_d;
      faddr_q <= faddr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    code_d  = code_q;
    halt_d  = halt_q;
    depth_d = depth_q;
    faddr_d = faddr_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      StRun: begin
        if (op_valid) begin
          if (err_code != 8'h00) begin
            state_d = StFault;
            code_d  = err_code;
            halt_d  = 1'b1;
            faddr_d = (op_code == OpLoad || op_code == OpStore) ? mem_addr : '0;
            if (fcnt_q != 4'd15) fcnt_d = fcnt_q + 4'd1;
          end else if (op_code != 3'd0 && op_code != 3'd7) begin
            grant_d = 1'b1;
            if (op_code == OpPush || op_code == OpCall) depth_d = depth_q + DEPTH_W'(1);
            if (op_code == OpPop  || op_code == OpRet)  depth_d = depth_q - DEPTH_W'(1);
          end
        end
      end
      StFault: begin
        // Any request arriving alongside the clear is dropped.
        if (err_clr) begin
          state_d = StRun;
          code_d  = 8'h00;
          halt_d  = 1'b0;
          faddr_d = '0;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    op_grant   = grant_q;
    ER_CDE     = code_q;
    halt       = halt_q;
    sp_depth   = depth_q;
    fault_addr = faddr_q;
    fault_cnt  = fcnt_q;
  end

endmodule

// File: tb/tb_er_cde_generator.sv
// Self-checking bench for er_cde_generator: behavioural model compared every cycle plus
// directed literal checks on the scenarios of interest.
module tb_er_cde_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op_code = 3'd0;
  logic [7:0] mem_addr = 8'h00;
  logic       err_clr = 1'b0;
  logic       op_grant;
  logic [7:0] ER_CDE;
  logic       halt;
  logic [4:0] sp_depth;
  logic [7:0] fault_addr;
  logic [3:0] fault_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  bit m_fault, m_grant;
  int m_code, m_depth, m_faddr, m_cnt;

  er_cde_generator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .mem_addr  (mem_addr),
    .err_clr   (err_clr),
    .op_grant  (op_grant),
    .ER_CDE    (ER_CDE),
    .halt      (halt),
    .sp_depth  (sp_depth),
    .fault_addr(fault_addr),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Error code an op would raise given the current depth, 0 if legal.
  function automatic int fault_of(input int op, input int addr, input int depth);
    case (op)
      1:       return (addr >= 240 && addr <= 255) ? 1 : 0;
      2:       return (addr >= 240 && addr <= 255) ? 2 : 0;
      3:       return (depth == 16) ? 3 : 0;
      5:       return (depth == 16) ? 6 : 0;
      4:       return (depth == 0) ? 4 : 0;
      6:       return (depth == 0) ? 5 : 0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fault <= 0; m_grant <= 0; m_code <= 0; m_depth <= 0; m_faddr <= 0; m_cnt <= 0;
    end else if (m_fault) begin
      m_grant <= 0;
      if (err_clr) begin
        m_fault <= 0; m_code <= 0; m_faddr <= 0;
      end
    end else if (op_valid && fault_of(op_code, mem_addr, m_depth) != 0) begin
      m_grant <= 0;
      m_fault <= 1;
      m_code  <= fault_of(op_code, mem_addr, m_depth);
      m_faddr <= (op_code == 1 || op_code == 2) ? int'(mem_addr) : 0;
      m_cnt   <= (m_cnt < 15) ? m_cnt + 1 : 15;
    end else if (op_valid && op_code >= 1 && op_code <= 6) begin
      m_grant <= 1;
      if (op_code == 3 || op_code == 5) m_depth <= m_depth + 1;
      if (op_code == 4 || op_code == 6) m_depth <= m_depth - 1;
    end else begin
      m_grant <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",  int'(op_grant),   int'(m_grant));
      check("code",   int'(ER_CDE),     m_code);
      check("halt",   int'(halt),       int'(m_fault));
      check("depth",  int'(sp_depth),   m_depth);
      check("faddr",  int'(fault_addr), m_faddr);
      check("fcnt",   int'(fault_cnt),  m_cnt);
    end
  end

  // Drive one request for one clock; returns 1 ns after the capturing edge.
  task automatic drive(input bit v, input int c, input int a, input bit clr);
    @(negedge clk);
    op_valid = v; op_code = 3'(c); mem_addr = 8'(a); err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    op_valid = 0; op_code = 3'd0; mem_addr = 8'h00; err_clr = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    // T1: async reset mid-cycle clears everything immediately
    repeat (3) drive(1, 3, 0, 0);
    check("t1_pre_depth", sp_depth, 3);
    check("t1_pre_grant", op_grant, 1);
    #2 rst_n = 0;
    #1;
    check("t1_grant", op_grant, 0);
    check("t1_depth", sp_depth, 0);
    check("t1_code", ER_CDE, 0);
    check("t1_halt", halt, 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;

    // NOP codes and err_clr in RUN have no effect
    drive(1, 0, 0, 0);
    check("nop0_grant", op_grant, 0);
    drive(1, 7, 0, 1);
    check("nop7_grant", op_grant, 0);
    check("nop7_code", ER_CDE, 0);

    // T2: fill stack, then overflow
    for (int i = 0; i < 16; i++) drive(1, 3, 0, 0);
    check("t2_depth16", sp_depth, 16);
    check("t2_grant16", op_grant, 1);
    drive(1, 3, 0, 0);
    check("t2_code", ER_CDE, 8'h03);
    check("t2_halt", halt, 1);
    check("t2_depth", sp_depth, 16);
    check("t2_fcnt", fault_cnt, 1);
    check("t2_grant", op_grant, 0);

    // T3: clear, then CALL on full stack
    drive(0, 0, 0, 1);
    check("t3_code_clr", ER_CDE, 0);
    check("t3_halt_clr", halt, 0);
    check("t3_depth_kept", sp_depth, 16);
    drive(1, 5, 0, 0);
    check("t3_code", ER_CDE, 8'h06);
    check("t3_fcnt", fault_cnt, 2);
    // clear together with a POP: POP is dropped
    drive(1, 4, 0, 1);
    check("clr_op_depth", sp_depth, 16);
    check("clr_op_grant", op_grant, 0);
    drive(1, 4, 0, 0);
    check("pop_after_clr", sp_depth, 15);

    // T4: RET on empty stack, POP while faulted
    reset_pulse();
    drive(1, 6, 0, 0);
    check("t4_code", ER_CDE, 8'h05);
    check("t4_faddr", fault_addr, 0);
    drive(1, 4, 0, 0);
    check("t4_code_held", ER_CDE, 8'h05);
    check("t4_grant", op_grant, 0);
    check("t4_depth", sp_depth, 0);
    drive(0, 0, 0, 1);

    // T5: address window edges
    drive(1, 1, 8'hEF, 0);
    check("t5_grant_ef", op_grant, 1);
    drive(1, 1, 8'hF0, 0);
    check("t5_code_f0", ER_CDE, 8'h01);
    check("t5_faddr_f0", fault_addr, 8'hF0);
    drive(0, 0, 0, 1);
    check("t5_faddr_clr", fault_addr, 0);
    drive(1, 2, 8'hFF, 0);
    check("t5_code_ff", ER_CDE, 8'h02);
    check("t5_faddr_ff", fault_addr, 8'hFF);
    drive(0, 0, 0, 1);
    drive(1, 2, 8'h00, 0);
    check("t5_grant_00", op_grant, 1);

    // T6: fault counter saturation
    reset_pulse();
    for (int i = 0; i < 17; i++) begin
      drive(1, 4, 0, 0);
      drive(0, 0, 0, 1);
    end
    check("t6_fcnt_sat", fault_cnt, 15);
    reset_pulse();
    #1;
    check("t6_fcnt_rst", fault_cnt, 0);
    drive(0, 0, 0, 0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
